fdtd_load_sequencer: RTL and testbench

- Upstream controller for the array of R_SIZE FDTD processing elements (PEs).
- Accepts an initial-condition word stream from the HPS over a valid/ready handshake and writes it into each PE's voltage memory in PE-major order: PE 0 addresses 0..Z_SIZE-1, then PE 1, and so on.
- After loading, it pulses the PE reset, holds computing_on until the PEs report finishing_fdtd, then reports done.
- It is the single owner of the PE array's target_pe/addr/data/we/computing_on lines.

---
 rtl/fdtd_load_sequencer.sv | 134 +++++++++++++
 tb/tb_fdtd_load_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fdtd_load_sequencer.sv
// fdtd_load_sequencer: streams HPS initial conditions into the PE voltage
// memories (PE-major), pulses the PE reset, then runs the array until PE 0
// reports finishing_fdtd. Sole driver of the PE array's memory/compute lines.
module fdtd_load_sequencer #(
    parameter int Z_SIZE        = 110,
    parameter int R_SIZE        = 20,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [26:0] in_data,
    output logic        in_ready,
    input  logic        finishing_fdtd,
    output logic        pe_rst,
    output logic [5:0]  target_pe,
    output logic [6:0]  addr,
    output logic [26:0] data,
    output logic        we,
    output logic        computing_on,
    output logic        busy,
    output logic        done,
    output logic [12:0] words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_PRST   = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int TOTAL = R_SIZE * Z_SIZE;
    // The 13-bit counter cannot represent 64*128; clamp the saturation point.
    localparam int SAT   = (TOTAL > 8191) ? 8191 : TOTAL;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [2:0]    state;
    logic [5:0]    wr_pe;
    logic [6:0]    wr_addr;
    logic [SW-1:0] settle_cnt;
    logic [1:0]    run_cnt;
    logic          accept;
    logic          last_word;

    assign in_ready  = (state == S_LOAD);
    assign accept    = in_valid && in_ready;
    assign last_word = (wr_pe == 6'(R_SIZE - 1)) && (wr_addr == 7'(Z_SIZE - 1));
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);

    // Sequencer FSM, write pointer and registered PE-array outputs.
    // rst and abort share one clearing path; abort wins over start/accept.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state        <= S_IDLE;
            wr_pe        <= '0;
            wr_addr      <= '0;
            settle_cnt   <= '0;
            run_cnt      <= '0;
            words_loaded <= '0;
            target_pe    <= '0;
            addr         <= '0;
            data         <= '0;
            we           <= 1'b0;
            pe_rst       <= 1'b0;
            computing_on <= 1'b0;
        end else begin
            we     <= 1'b0;
            pe_rst <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_LOAD;
                        wr_pe        <= '0;
                        wr_addr      <= '0;
                        words_loaded <= '0;
                        target_pe    <= '0;
                        addr         <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        we        <= 1'b1;
                        data      <= in_data;
                        target_pe <= wr_pe;
                        addr      <= wr_addr;
                        if (words_loaded != 13'(SAT))
                            words_loaded <= words_loaded + 13'd1;
                        // Pointer parks on the final word so it stays valid after LOAD.
                        if (last_word) begin
                            state      <= S_SETTLE;
                            settle_cnt <= '0;
                        end else if (wr_addr == 7'(Z_SIZE - 1)) begin
                            wr_addr <= '0;
                            wr_pe   <= wr_pe + 6'd1;
                        end else begin
                            wr_addr <= wr_addr + 7'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                        state  <= S_PRST;
                        pe_rst <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_PRST: begin
                    state        <= S_RUN;
                    computing_on <= 1'b1;
                    run_cnt      <= '0;
                    target_pe    <= '0;
                    addr         <= '0;
                    data         <= '0;
                end
                S_RUN: begin
                    // finishing_fdtd may be stale for two cycles after PE reset.
                    if (run_cnt != 2'd2) begin
                        run_cnt <= run_cnt + 2'd1;
                    end else if (finishing_fdtd) begin
                        computing_on <= 1'b0;
                        state        <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdtd_load_sequencer.sv
// Scoreboard bench for fdtd_load_sequencer with R_SIZE=2, Z_SIZE=10.
module tb_fdtd_load_sequencer;

    localparam int Z = 10;
    localparam int R = 2;
    localparam int TOTAL = R * Z;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [26:0] in_data = '0;
    logic        finishing_fdtd = 1'b0;
    logic        in_ready, pe_rst, we, computing_on, busy, done;
    logic [5:0]  target_pe;
    logic [6:0]  addr;
    logic [26:0] data;
    logic [12:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0;
    int prst_cnt = 0;
    int tb_phase = 0;   // 0 idle/done, 1 loading, 2 loaded/running
    int tb_cnt = 0;
    logic [39:0] exp_q[$];

    fdtd_load_sequencer #(.Z_SIZE(Z), .R_SIZE(R), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .finishing_fdtd(finishing_fdtd), .pe_rst(pe_rst),
        .target_pe(target_pe), .addr(addr), .data(data), .we(we),
        .computing_on(computing_on), .busy(busy), .done(done),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks accepts and pushes the expected write per word.
    always @(posedge clk) begin
        if (rst || abort) begin
            tb_phase = 0;
            tb_cnt = 0;
            exp_q.delete();
        end else if (tb_phase == 1 && in_valid) begin
            exp_q.push_back({6'(tb_cnt / Z), 7'(tb_cnt % Z), in_data});
            tb_cnt++;
            if (tb_cnt == TOTAL) tb_phase = 2;
        end else if (tb_phase == 0 && start) begin
            tb_phase = 1;
            tb_cnt = 0;
        end
    end

    // Compare writes and handshake away from the active edge.
    always @(negedge clk) begin
        logic [39:0] e;
        chk("in_ready", in_ready, tb_phase == 1);
        if (pe_rst) prst_cnt++;
        if (we) begin
            we_cnt++;
            chk("wr_latency", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write", {target_pe, addr, data}, e);
            end
        end else if (exp_q.size() != 0) begin
            chk("missing_we", exp_q.size(), 0);
            exp_q.delete();
        end
    end

    task automatic load_words(input bit bubble, input int base, input bit start_mid);
        for (int i = 0; i < TOTAL; i++) begin
            in_valid = 1'b1;
            in_data = 27'(base + i);
            start = start_mid && (i == 3);
            tick();
            start = 1'b0;
            if (bubble && i != TOTAL - 1) begin
                in_valid = 1'b0;
                tick();
                chk("bubble_we", we, 0);
            end
        end
        in_valid = 1'b0;
    endtask

    // From the edge that accepted the last word through the first RUN cycle.
    task automatic post_load();
        chk("ready_low", in_ready, 0);
        chk("last_we", we, 1);
        chk("words20", words_loaded, TOTAL);
        chk("busy_load", busy, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) chk("settle_we", we, 0);
            chk("pe_rst_settle", pe_rst, k == 3);
            chk("comp_off_settle", computing_on, 0);
        end
        tick();
        chk("pe_rst_1cyc", pe_rst, 0);
        chk("comp_on", computing_on, 1);
        chk("run_tpe", target_pe, 0);
        chk("run_addr", addr, 0);
        chk("run_data", data, 0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        chk("done_reached", done, 1);
        chk("comp_off_done", computing_on, 0);
        chk("busy_done", busy, 0);
    endtask

    initial begin
        int pr;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_state", {in_ready, pe_rst, we, computing_on, busy, done}, 0);
        chk("rst_vals", {target_pe, addr, data, words_loaded}, 0);

        // Nominal load, run, completion
        start = 1'b1; tick(); start = 1'b0;
        chk("busy_start", busy, 1);
        load_words(1'b0, 0, 1'b0);
        post_load();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("comp_hold", computing_on, 1);
        end
        start = 1'b1; tick(); start = 1'b0;
        chk("start_run_ign", busy, 1);
        chk("start_run_words", words_loaded, TOTAL);
        finishing_fdtd = 1'b1;
        wait_done();
        finishing_fdtd = 1'b0;
        tb_phase = 0;

        // Restart from DONE, bubbled input, stale finishing_fdtd
        finishing_fdtd = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_words", words_loaded, 0);
        load_words(1'b1, 50, 1'b1);
        post_load();
        tick();
        chk("ign1_comp", computing_on, 1);
        chk("ign1_done", done, 0);
        tick();
        chk("ign2_comp", computing_on, 1);
        chk("ign2_done", done, 0);
        tick();
        chk("fin_comp", computing_on, 0);
        chk("fin_done", done, 1);
        chk("fin_busy", busy, 0);
        finishing_fdtd = 1'b0;
        tb_phase = 0;

        // Abort mid-LOAD with a word offered in the same cycle
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 27'(100 + i);
            tick();
        end
        chk("words7", words_loaded, 7);
        pr = prst_cnt;
        in_valid = 1'b1; in_data = 27'd999; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_ready", in_ready, 0);
        chk("abort_words", words_loaded, 0);
        chk("abort_busy", busy, 0);
        chk("abort_we", we, 0);
        repeat (3) tick();
        chk("abort_no_prst", prst_cnt, pr);

        // Reset during RUN
        start = 1'b1; tick(); start = 1'b0;
        load_words(1'b0, 200, 1'b0);
        post_load();
        repeat (2) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rrst_comp", computing_on, 0);
        chk("rrst_state", {in_ready, pe_rst, we, busy, done}, 0);
        chk("rrst_vals", {target_pe, addr, data, words_loaded}, 0);

        tick();
        chk("sb_empty", exp_q.size(), 0);
        chk("we_total", we_cnt, 3 * TOTAL + 7);
        chk("prst_total", prst_cnt, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
